// File: rtl/dfsm_feed_seq.sv
// Feed sequencer for the DFSM MAC-array controller: takes one run configuration,
// shifts it serially into the DFSM, then paces buffered words into it period by period.
module dfsm_feed_seq #(
    parameter int MAX_nPERIOD = 8,
    parameter int MAX_nLMAC   = 12288,
    parameter int MAX_nSHFT   = 192,
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [$clog2(MAX_nPERIOD)-1:0] cfg_period,
    input  logic [$clog2(MAX_nLMAC)-1:0]   cfg_nlmac,
    input  logic [$clog2(MAX_nSHFT)-1:0]   cfg_nshft,
    output logic                           cfg_err,
    input  logic                           din_valid,
    output logic                           din_ready,
    input  logic [DATA_W-1:0]              din,
    output logic                           config_en,
    output logic                           iconfig,
    output logic                           start,
    output logic                           in_en,
    output logic [DATA_W-1:0]              dout,
    output logic                           busy,
    output logic                           done
);

    localparam int PW  = $clog2(MAX_nPERIOD);
    localparam int LW  = $clog2(MAX_nLMAC);
    localparam int SW  = $clog2(MAX_nSHFT);
    localparam int CL  = PW + LW + SW;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int SCW = $clog2(CL + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, START, FEED, GAP} state_t;

    state_t            state;
    logic [CL-1:0]     cw;
    logic [CL-1:0]     cw_in;
    logic [CL-1:0]     sh_reg;
    logic [SCW-1:0]    sh_cnt;
    logic [LW:0]       wcnt;
    logic [PW:0]       pcnt;
    logic [SW+1:0]     gcnt;
    logic [PW-1:0]     r_period;
    logic [LW-1:0]     r_nlmac;
    logic [SW-1:0]     r_nshft;
    logic              cfg_zero;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nx;
    logic              push;
    logic              pop_p0;

    assign cw_in    = {cfg_period, cfg_nlmac, cfg_nshft};
    assign cfg_zero = (cfg_period == '0) || (cfg_nlmac == '0) || (cfg_nshft == '0);
    assign r_period = cw[CL-1 -: PW];
    assign r_nlmac  = cw[SW +: LW];
    assign r_nshft  = cw[SW-1:0];

    assign push   = din_valid && din_ready;
    assign pop_p0 = (state == FEED) && (count != '0);

    always_comb begin
        count_nx = count;
        case ({push, pop_p0})
            2'b10:   count_nx = count + (AW+1)'(1);
            2'b01:   count_nx = count - (AW+1)'(1);
            default: count_nx = count;
        endcase
    end

    // Storage is never reset; only the pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            din_ready <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_p0) rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nx;
            din_ready <= (count_nx != (AW+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cw        <= '0;
            sh_reg    <= '0;
            sh_cnt    <= '0;
            wcnt      <= '0;
            pcnt      <= '0;
            gcnt      <= '0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            config_en <= 1'b0;
            iconfig   <= 1'b0;
            start     <= 1'b0;
            in_en     <= 1'b0;
            dout      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start   <= 1'b0;
            in_en   <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        cw <= cw_in;
                        if (cfg_zero) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                            config_en <= 1'b1;
                            iconfig   <= cw_in[0];
                            sh_reg    <= cw_in >> 1;
                            sh_cnt    <= SCW'(1);
                        end
                    end
                end
                // LSB first: the DFSM shifts in at its MSB so the word lands in order.
                SHIFT: begin
                    if (sh_cnt == SCW'(CL)) begin
                        config_en <= 1'b0;
                        iconfig   <= 1'b0;
                        start     <= 1'b1;
                        state     <= START;
                    end else begin
                        iconfig <= sh_reg[0];
                        sh_reg  <= sh_reg >> 1;
                        sh_cnt  <= sh_cnt + SCW'(1);
                    end
                end
                START: begin
                    wcnt  <= '0;
                    pcnt  <= '0;
                    state <= FEED;
                end
                FEED: begin
                    if (pop_p0) begin
                        in_en <= 1'b1;
                        dout  <= mem[rd_ptr];
                        wcnt  <= wcnt + (LW+1)'(1);
                        if (wcnt + (LW+1)'(1) == {1'b0, r_nlmac}) begin
                            state <= GAP;
                            gcnt  <= '0;
                        end
                    end
                end
                // GAP spans nshft+2 cycles starting with the final in_en of the period.
                GAP: begin
                    if (gcnt == {2'b00, r_nshft} + (SW+2)'(1)) begin
                        pcnt <= pcnt + (PW+1)'(1);
                        if (pcnt + (PW+1)'(1) < {1'b0, r_period}) begin
                            state <= FEED;
                            wcnt  <= '0;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                        end
                    end else begin
                        gcnt <= gcnt + (SW+2)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfsm_feed_seq.sv
// Scoreboard bench for dfsm_feed_seq: stimulus queues expected config bits and words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dfsm_feed_seq;

    localparam int PW = 3;
    localparam int LW = 14;
    localparam int SW = 8;
    localparam int CL = PW + LW + SW;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_period = '0;
    logic [LW-1:0] cfg_nlmac = '0;
    logic [SW-1:0] cfg_nshft = '0;
    logic          cfg_err;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] din = '0;
    logic          config_en, iconfig, start, in_en, busy, done;
    logic [DW-1:0] dout;

    dfsm_feed_seq #(
        .MAX_nPERIOD(8), .MAX_nLMAC(12288), .MAX_nSHFT(192), .DATA_W(DW), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_nlmac(cfg_nlmac), .cfg_nshft(cfg_nshft),
        .cfg_err(cfg_err),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .config_en(config_en), .iconfig(iconfig), .start(start),
        .in_en(in_en), .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    bit            exp_bits[$];
    logic [DW-1:0] exp_words[$];
    int            exp_start_cyc = -1;
    int            exp_done_cyc  = -1;
    int            exp_err_cyc   = -1;
    bit            run_on = 0, strict = 0, starve = 0;
    int            r_period, r_nlmac, r_nshft;
    int            wcnt, pcnt, last_en, first_cyc;
    int            seen_words = 0;
    logic [DW-1:0] held_dout = '0;
    bit            mb;
    logic [DW-1:0] mw;
    int            n_vec = 0, n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_ok(input string name, input bit cond, input longint act, input longint bound);
        n_vec++;
        if (!cond) begin
            n_err++;
            $display("FAIL %s: got %0d bound %0d (cycle %0d)", name, act, bound, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (config_en) begin
                if (exp_bits.size() == 0) chk("config_en_spurious", 1, 0);
                else begin
                    mb = exp_bits.pop_front();
                    chk("iconfig", iconfig, mb);
                end
            end
            if (cyc == exp_start_cyc) begin
                chk("start", start, 1);
                chk("start_busy", busy, 1);
                chk("cfg_bits_left", exp_bits.size(), 0);
                exp_start_cyc = -1;
            end else if (start) chk("start_spurious", 1, 0);
            if (cyc == exp_err_cyc) begin
                chk("cfg_err", cfg_err, 1);
                chk("cfg_err_ready", cfg_ready, 1);
                chk("cfg_err_busy", busy, 0);
                exp_err_cyc = -1;
            end else if (cfg_err) chk("cfg_err_spurious", 1, 0);
            if (cyc == exp_done_cyc) begin
                chk("done", done, 1);
                chk("done_busy", busy, 0);
                chk("done_cfg_ready", cfg_ready, 1);
                exp_done_cyc = -1;
            end else if (done) chk("done_spurious", 1, 0);
            if (in_en) begin
                if (!run_on || exp_words.size() == 0) chk("in_en_spurious", 1, 0);
                else begin
                    mw = exp_words.pop_front();
                    chk("dout", dout, mw);
                    chk("busy_feed", busy, 1);
                    held_dout = mw;
                    seen_words++;
                    if (wcnt == 0 && pcnt == 0) begin
                        if (strict) chk("first_in_en_cyc", cyc, first_cyc);
                        else chk_ok("first_in_en_early", cyc >= first_cyc, cyc, first_cyc);
                    end else if (wcnt == 0) begin
                        if (strict) chk("gap_len", cyc - last_en, r_nshft + 3);
                        else chk_ok("gap_short", cyc - last_en >= r_nshft + 3, cyc - last_en, r_nshft + 3);
                    end else if (strict) begin
                        chk("burst", cyc - last_en, 1);
                    end else if (starve && pcnt == 0) begin
                        chk_ok("isolated", cyc - last_en >= 2, cyc - last_en, 2);
                    end
                    last_en = cyc;
                    wcnt++;
                    if (wcnt == r_nlmac) begin
                        wcnt = 0;
                        pcnt++;
                        if (pcnt == r_period) begin
                            run_on = 0;
                            exp_done_cyc = cyc + r_nshft + 2;
                        end
                    end
                end
            end else begin
                chk("dout_hold", dout, held_dout);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_din_ready"}, din_ready, 0);
        chk({tag, "_config_en"}, config_en, 0);
        chk({tag, "_iconfig"}, iconfig, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_in_en"}, in_en, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; cfg_valid = 1'b0; din_valid = 1'b0;
        @(posedge clk); #1;
        exp_bits.delete(); exp_words.delete();
        run_on = 0; exp_start_cyc = -1; exp_done_cyc = -1; exp_err_cyc = -1;
        held_dout = '0;
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_cfg_ready", cfg_ready, 1);
        chk("rel_din_ready", din_ready, 1);
        chk("rel_busy", busy, 0);
    endtask

    task automatic apply_cfg(input int p, input int l, input int s, input bit st, input bit sv,
                             output int t, output bit ok);
        int budget = 0;
        logic [CL-1:0] cwv;
        ok = 0;
        t = -1;
        cwv = {p[PW-1:0], l[LW-1:0], s[SW-1:0]};
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_period = p[PW-1:0]; cfg_nlmac = l[LW-1:0]; cfg_nshft = s[SW-1:0];
        @(negedge clk);
        while (!cfg_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cfg_ready) begin
            chk("cfg_ready_timeout", 0, 1);
            cfg_valid = 1'b0;
            return;
        end
        t = cyc;
        if (p == 0 || l == 0 || s == 0) begin
            exp_err_cyc = t + 1;
        end else begin
            for (int k = 0; k < CL; k++) exp_bits.push_back(cwv[k]);
            exp_start_cyc = t + CL + 1;
            first_cyc = t + CL + 3;
            r_period = p; r_nlmac = l; r_nshft = s;
            wcnt = 0; pcnt = 0;
            strict = st; starve = sv;
            run_on = 1;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        ok = 1;
    endtask

    task automatic push_words(input int n, input int mode);
        int sent = 0;
        int guard = 0;
        logic [DW-1:0] w;
        w = DW'($urandom);
        while (sent < n && guard < 5000) begin
            @(posedge clk); #1;
            din_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 3 == 0) : ($urandom_range(0, 1) == 1);
            din = w;
            @(negedge clk);
            if (din_valid && din_ready) begin
                exp_words.push_back(w);
                sent++;
                w = DW'($urandom);
            end
            guard++;
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        if (sent < n) chk("push_timeout", sent, n);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while ((run_on || exp_done_cyc >= 0 || exp_start_cyc >= 0 || exp_err_cyc >= 0) && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        if (run_on || exp_done_cyc >= 0 || exp_start_cyc >= 0 || exp_err_cyc >= 0) begin
            chk("run_timeout", 0, 1);
            do_reset();
        end
    endtask

    initial begin
        int t;
        bit ok;
        int p, l, s, base, guard;

        // Reset values, then release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("por");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("por_cfg_ready", cfg_ready, 1);
        chk("por_din_ready", din_ready, 1);

        // Backpressure: 20 offered words with no run active
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            din_valid = 1'b1;
            din = DW'($urandom);
            @(negedge clk);
            chk("din_ready_bp", din_ready, (i < 16));
            if (din_ready) exp_words.push_back(din);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;

        // Test-plan config on a full FIFO; din_ready recovers after the first pop
        apply_cfg(2, 4, 3, 1, 0, t, ok);
        if (ok) begin
            chk("busy_after_accept", busy, 1);
            while (cyc < t + CL + 2) @(negedge clk);
            chk("din_ready_before_pop", din_ready, 0);
            @(negedge clk);
            chk("din_ready_after_pop", din_ready, 1);
        end
        wait_done(500);

        // Same config drains the remaining 8 words
        apply_cfg(2, 4, 3, 1, 0, t, ok);
        wait_done(500);

        // Zero fields are rejected
        apply_cfg(2, 4, 0, 0, 0, t, ok);
        wait_done(50);
        apply_cfg(0, 4, 3, 0, 0, t, ok);
        wait_done(50);
        apply_cfg(2, 0, 3, 0, 0, t, ok);
        wait_done(50);
        repeat (30) @(negedge clk);
        chk("zero_busy", busy, 0);
        chk("zero_cfg_ready", cfg_ready, 1);

        // Starved FIFO: one word every 3 cycles once FEED is reached
        apply_cfg(2, 4, 3, 0, 1, t, ok);
        if (ok) begin
            while (cyc < t + CL + 2) @(negedge clk);
            push_words(8, 1);
        end
        wait_done(2000);

        // Randomized runs with random pacing
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(1, 4);
            l = $urandom_range(1, 10);
            s = $urandom_range(1, 12);
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 0;
                    1: l = 0;
                    default: s = 0;
                endcase
            end
            if (p == 0 || l == 0 || s == 0) begin
                apply_cfg(p, l, s, 0, 0, t, ok);
                wait_done(50);
            end else begin
                fork
                    push_words(p * l, 2);
                    begin
                        apply_cfg(p, l, s, 0, 0, t, ok);
                        wait_done(4000);
                    end
                join
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Reset in FEED after two words, then a normal run
        push_words(8, 0);
        base = seen_words;
        apply_cfg(2, 4, 3, 1, 0, t, ok);
        guard = 0;
        while (seen_words < base + 2 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("mid_words_seen", seen_words >= base + 2, 1);
        do_reset();
        push_words(4, 0);
        apply_cfg(1, 4, 2, 1, 0, t, ok);
        wait_done(500);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
